// File: rtl/ddr_rd_sched.sv
// ddr_rd_sched: credit-limited read command scheduler for a DDR ring buffer
module ddr_rd_sched #(
    parameter int ADDR_W     = 27,
    parameter int BASE_ADDR  = 0,
    parameter int RING_WORDS = 1024,
    parameter int ADDR_STEP  = 8,
    parameter int MAX_OUT    = 8
) (
    input  logic                          rd_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          word_commit,
    input  logic                          word_consumed,
    input  logic                          fifo_full,
    output logic                          cmd_req,
    output logic [ADDR_W-1:0]             cmd_addr,
    input  logic                          cmd_ack,
    output logic [$clog2(RING_WORDS):0]   avail_cnt,
    output logic [$clog2(MAX_OUT):0]      outstanding,
    output logic [2:0]                    err_flags
);
    localparam int IW = RING_WORDS > 1 ? $clog2(RING_WORDS) : 1;
    localparam int AW = $clog2(RING_WORDS) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        GAP   = 4'b0100,
        FLUSH = 4'b1000
    } state_t;

    state_t        state, nxt;
    logic          pend;
    logic [IW-1:0] rd_idx;
    logic          ack, com, con, ring_full, can_issue;

    // Only an ack during ISSUE counts; commit/consume are dropped while flushing
    assign ack       = state == ISSUE && cmd_ack;
    assign com       = word_commit && state != FLUSH;
    assign con       = word_consumed && state != FLUSH;
    assign ring_full = avail_cnt == AW'(RING_WORDS);
    assign can_issue = enable && avail_cnt != '0 && outstanding < OW'(MAX_OUT) && !pend;
    assign cmd_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx) * ADDR_W'(ADDR_STEP);

    // Next state and command request; a request is never withdrawn before its ack
    always_comb begin
        nxt     = IDLE;
        cmd_req = 1'b0;
        case (state)
            IDLE:  nxt = flush ? FLUSH : can_issue ? ISSUE : IDLE;
            ISSUE: begin
                cmd_req = 1'b1;
                nxt     = !cmd_ack ? ISSUE : (pend || flush) ? FLUSH : GAP;
            end
            GAP:   nxt = flush ? FLUSH : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge rd_clk) begin
        state <= rst ? IDLE : nxt;
    end

    // Credit counters, ring read index, deferred flush and sticky error flags
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            pend        <= 1'b0;
            rd_idx      <= '0;
            avail_cnt   <= '0;
            outstanding <= '0;
            err_flags   <= '0;
        end else begin
            pend        <= state == FLUSH ? 1'b0 : pend | (state == ISSUE && flush);
            rd_idx      <= state == FLUSH ? '0 :
                           !ack ? rd_idx :
                           rd_idx == IW'(RING_WORDS - 1) ? '0 : rd_idx + 1'b1;
            avail_cnt   <= state == FLUSH ? '0 :
                           (com && !ack && !ring_full) ? avail_cnt + 1'b1 :
                           (ack && !com) ? avail_cnt - 1'b1 : avail_cnt;
            outstanding <= state == FLUSH ? '0 :
                           (ack && !con) ? outstanding + 1'b1 :
                           (con && !ack && outstanding != '0) ? outstanding - 1'b1 : outstanding;
            err_flags   <= err_flags | {fifo_full,
                                        con && !ack && outstanding == '0,
                                        com && !ack && ring_full};
        end
    end
endmodule
